// File: rtl/cofi_sharpen.sv
// ----------------------------------------------------------------------------
// cofi_sharpen
//
// Horizontal edge-enhancement filter for the RGB video chain. It is the
// high-pass counterpart of the composite-blend low-pass stage. Per channel:
//
//     out = sat( d + floor(coefficient * (d - prev) / 16) )
//
// Two register stages sit between input and output for both colour and sync.
// Stage 1 captures the pixel and the boost product. It advances only on
// trigger clocks, so a scandoubled pixel gives the same result on both of its
// clocks. Stage 2 adds the product, saturates, and registers the output.
//
// Optional feature (define COFI_SHARPEN_CORING_EN):
//     noise coring. Any |delta| <= 2 is treated as 0 before the multiply.
//
// Ports:
//     clk                  video-chain clock
//     reset                asynchronous active-high reset
//     enable               1 = sharpen, 0 = bypass with identical latency
//     coefficient          boost strength 0..15 in sixteenths
//     scandoubler_disable  1 = each pixel is held for 2 clocks
//     hblank/vblank/hs/vs  sync and blank inputs
//     red/green/blue       colour inputs
//     *_out                sync and blank delayed 2 clocks, filtered colour
// ----------------------------------------------------------------------------
module cofi_sharpen #(
    parameter int VIDEO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [3:0]             coefficient,
    input  logic                   scandoubler_disable,
    input  logic                   hblank,
    input  logic                   vblank,
    input  logic                   hs,
    input  logic                   vs,
    input  logic [VIDEO_DEPTH-1:0] red,
    input  logic [VIDEO_DEPTH-1:0] green,
    input  logic [VIDEO_DEPTH-1:0] blue,
    output logic                   hblank_out,
    output logic                   vblank_out,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic [VIDEO_DEPTH-1:0] red_out,
    output logic [VIDEO_DEPTH-1:0] green_out,
    output logic [VIDEO_DEPTH-1:0] blue_out
);

    localparam int W = VIDEO_DEPTH;

`ifdef COFI_SHARPEN_CORING_EN
    localparam logic signed [W:0] CORE_LIM = 2;
`endif

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } line_state_t;

    logic        trigger_reg;
    line_state_t state_reg;
    line_state_t cur_state;
    logic        boost_en;
    logic [3:0]  sync_s1_reg;
    logic [3:0]  sync_s2_reg;

    logic [W-1:0] pix_in  [3];
    logic [W-1:0] pix_out [3];

    assign pix_in[0] = red;
    assign pix_in[1] = green;
    assign pix_in[2] = blue;

    // Step enable. It is held high through blanking, so the first active
    // clock after hblank is always a step. That aligns the 2-clock cadence to
    // the start of each line when scandoubling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trigger_reg <= 1'b1;
        end else begin
            trigger_reg <= !trigger_reg || hblank || !scandoubler_disable;
        end
    end

    // cur_state is the state of the current clock. Blanking or bypass takes
    // effect immediately. The first active step of a line is FIRST, so it has
    // no left neighbour to difference against.
    always_comb begin
        cur_state = ST_RUN;
        if (hblank || !enable) begin
            cur_state = ST_BLANK;
        end else if (state_reg == ST_BLANK) begin
            cur_state = ST_FIRST;
        end
    end

    // The state advances only on steps. A drop to BLANK is taken on any clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_BLANK;
        end else if (trigger_reg || cur_state == ST_BLANK) begin
            state_reg <= cur_state;
        end
    end

    assign boost_en = (cur_state == ST_RUN);

    // Sync and blank shift register, packed as {hblank, vblank, hs, vs}.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_s1_reg <= 4'b1100;
            sync_s2_reg <= 4'b1100;
        end else begin
            sync_s1_reg <= {hblank, vblank, hs, vs};
            sync_s2_reg <= sync_s1_reg;
        end
    end

    assign hblank_out = sync_s2_reg[3];
    assign vblank_out = sync_s2_reg[2];
    assign hs_out     = sync_s2_reg[1];
    assign vs_out     = sync_s2_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [W-1:0]          d_reg;
            logic [W-1:0]          prev_reg;
            logic [W-1:0]          out_reg;
            logic signed [W+4:0]   prod_reg;
            logic signed [W:0]     delta_raw;
            logic signed [W:0]     delta;
            logic signed [W+4:0]   delta_ext;
            logic signed [W+4:0]   coef_ext;
            logic signed [W+4:0]   prod_next;
            logic signed [W+4:0]   prod_sh;
            logic [W+5:0]          sum;

            always_comb begin
                // A modular (W+1)-bit difference of zero-extended pixels is
                // the exact two's-complement signed delta.
                delta_raw = {1'b0, pix_in[gi]} - {1'b0, prev_reg};
                delta     = boost_en ? delta_raw : '0;
`ifdef COFI_SHARPEN_CORING_EN
                if ((delta_raw <= CORE_LIM) && (delta_raw >= -CORE_LIM)) begin
                    delta = '0;
                end
`endif
                delta_ext = {{4{delta[W]}}, delta};
                coef_ext  = {{(W + 1){1'b0}}, coefficient};
                // 15 * -(2^W - 1) still fits in W+5 signed bits.
                prod_next = coef_ext * delta_ext;
                // The arithmetic shift floors toward minus infinity.
                prod_sh   = prod_reg >>> 4;
                // Bit W+5 of sum is the sign. Bits W+4..W are the overflow.
                sum       = {6'b0, d_reg} + {prod_sh[W+4], prod_sh};
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    d_reg    <= '0;
                    prev_reg <= '0;
                    prod_reg <= '0;
                end else if (trigger_reg) begin
                    d_reg    <= pix_in[gi];
                    prev_reg <= pix_in[gi];
                    prod_reg <= prod_next;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_reg <= '0;
                end else if (sum[W+5]) begin
                    out_reg <= '0;
                end else if (|sum[W+4:W]) begin
                    out_reg <= '1;
                end else begin
                    out_reg <= sum[W-1:0];
                end
            end

            assign pix_out[gi] = out_reg;
        end
    endgenerate

    assign red_out   = pix_out[0];
    assign green_out = pix_out[1];
    assign blue_out  = pix_out[2];

endmodule

// File: tb/tb_cofi_sharpen.sv
// ----------------------------------------------------------------------------
// tb_cofi_sharpen
//
// Self-checking bench for cofi_sharpen (VIDEO_DEPTH = 8). A pixel-level
// reference model predicts every output on every clock:
//   - sampling cadence,
//   - "has a left neighbour on this line",
//   - boost with floor division and saturation.
// Directed sequences with hand-computed results pin the model. A randomized
// multi-line run follows.
// Honours COFI_SHARPEN_CORING_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_cofi_sharpen;

    typedef int quad_t [4];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] coefficient = 4'd0;
    logic       scandoubler_disable = 1'b0;
    logic       hblank = 1'b1;
    logic       vblank = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic [7:0] red = 8'd0;
    logic [7:0] green = 8'd0;
    logic [7:0] blue = 8'd0;
    logic       hblank_out, vblank_out, hs_out, vs_out;
    logic [7:0] red_out, green_out, blue_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cofi_sharpen #(.VIDEO_DEPTH(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .coefficient         (coefficient),
        .scandoubler_disable (scandoubler_disable),
        .hblank              (hblank),
        .vblank              (vblank),
        .hs                  (hs),
        .vs                  (vs),
        .red                 (red),
        .green               (green),
        .blue                (blue),
        .hblank_out          (hblank_out),
        .vblank_out          (vblank_out),
        .hs_out              (hs_out),
        .vs_out              (vs_out),
        .red_out             (red_out),
        .green_out           (green_out),
        .blue_out            (blue_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_div16(input int p);
        int r;
        r = p % 16;
        if (r < 0) r += 16;
        return (p - r) / 16;
    endfunction

    function automatic int cored(input int dl);
`ifdef COFI_SHARPEN_CORING_EN
        if (dl >= -2 && dl <= 2) return 0;
`endif
        return dl;
    endfunction

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    int         m_trig = 1;        // this clock is a sampling clock
    int         m_pos = 0;         // active samples taken so far on this line
    int         m_prev [3] = '{0, 0, 0};
    int         m_held [3] = '{0, 0, 0};
    int         pipe_col [3] = '{0, 0, 0};
    int         exp_col [3] = '{0, 0, 0};
    logic [3:0] pipe_sync = 4'b1100;
    logic [3:0] exp_sync = 4'b1100;

    always @(posedge clk or posedge reset) begin
        int  pix [3];
        int  c;
        bit  active;
        if (reset) begin
            m_trig = 1;
            m_pos = 0;
            for (int k = 0; k < 3; k++) begin
                m_prev[k] = 0;
                m_held[k] = 0;
                pipe_col[k] = 0;
                exp_col[k] = 0;
            end
            pipe_sync = 4'b1100;
            exp_sync = 4'b1100;
        end else begin
            pix[0] = int'(red);
            pix[1] = int'(green);
            pix[2] = int'(blue);
            c = int'(coefficient);
            active = !hblank && enable;
            if (!active) m_pos = 0;
            if (m_trig != 0) begin
                for (int k = 0; k < 3; k++) begin
                    if (active && m_pos > 0)
                        m_held[k] = clamp8(pix[k] + floor_div16(c * cored(pix[k] - m_prev[k])));
                    else
                        m_held[k] = pix[k];
                    m_prev[k] = pix[k];
                end
                if (active) m_pos++;
            end
            for (int k = 0; k < 3; k++) begin
                exp_col[k] = pipe_col[k];
                pipe_col[k] = m_held[k];
            end
            exp_sync = pipe_sync;
            pipe_sync = {hblank, vblank, hs, vs};
            m_trig = ((m_trig == 0) || hblank || !scandoubler_disable) ? 1 : 0;
        end
    end

    // One compare process: every clock, all outputs against the model.
    always @(negedge clk) begin
        chk("red_out",    int'(red_out),    exp_col[0]);
        chk("green_out",  int'(green_out),  exp_col[1]);
        chk("blue_out",   int'(blue_out),   exp_col[2]);
        chk("hblank_out", int'(hblank_out), int'(exp_sync[3]));
        chk("vblank_out", int'(vblank_out), int'(exp_sync[2]));
        chk("hs_out",     int'(hs_out),     int'(exp_sync[1]));
        chk("vs_out",     int'(vs_out),     int'(exp_sync[0]));
    end

    // ---------------- stimulus ----------------
    task automatic px(input int r, input int g, input int b, input logic h);
        red = 8'(r);
        green = 8'(g);
        blue = 8'(b);
        hblank = h;
        @(posedge clk);
        #1;
    endtask

    // Two blank clocks (pixel 10, hs pulsed on the first), then four active
    // pixels, then one blank. Each red_out is checked one clock after its
    // pixel is sampled.
    task automatic seq4(input string nm, input int coef, input logic sdd, input logic en,
                        input quad_t p, input quad_t e);
        coefficient = 4'(coef);
        scandoubler_disable = sdd;
        enable = en;
        hs = 1'b1;
        px(10, 10, 10, 1'b1);
        hs = 1'b0;
        px(10, 10, 10, 1'b1);
        chk({nm, " hs_out lead"}, int'(hs_out), 1);
        px(p[0], p[0], p[0], 1'b0);
        chk({nm, " hblank_out lag"}, int'(hblank_out), 1);
        chk({nm, " hs_out lag"}, int'(hs_out), 0);
        for (int i = 1; i < 4; i++) begin
            px(p[i], p[i], p[i], 1'b0);
            if (i == 1) chk({nm, " hblank_out fall"}, int'(hblank_out), 0);
            chk($sformatf("%s px%0d", nm, i - 1), int'(red_out), e[i - 1]);
        end
        px(10, 10, 10, 1'b1);
        chk($sformatf("%s px3", nm), int'(red_out), e[3]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int line_len, blank_len, pv;
        repeat (3) @(posedge clk);
        #1;
        chk("reset red_out", int'(red_out), 0);
        chk("reset hblank_out", int'(hblank_out), 1);
        chk("reset hs_out", int'(hs_out), 0);
        reset = 1'b0;

        seq4("flat",    8, 1'b0, 1'b1, '{50, 50, 50, 50},     '{50, 50, 50, 50});
        seq4("rise",    4, 1'b0, 1'b1, '{100, 100, 132, 132}, '{100, 100, 140, 132});
        seq4("satur",   8, 1'b0, 1'b1, '{64, 192, 192, 192},  '{64, 255, 192, 192});
        seq4("fall",    8, 1'b0, 1'b1, '{192, 64, 64, 64},    '{192, 0, 64, 64});
        seq4("fall15", 15, 1'b0, 1'b1, '{200, 0, 0, 0},       '{200, 0, 0, 0});
        seq4("line_a",  8, 1'b0, 1'b1, '{10, 10, 10, 10},     '{10, 10, 10, 10});
        seq4("line_b",  8, 1'b0, 1'b1, '{200, 200, 200, 200}, '{200, 200, 200, 200});
        seq4("dbl",     4, 1'b1, 1'b1, '{100, 100, 132, 132}, '{100, 100, 140, 140});
        seq4("bypass",  4, 1'b1, 1'b0, '{100, 100, 132, 132}, '{100, 100, 132, 132});
        seq4("coef0",   0, 1'b0, 1'b1, '{3, 250, 7, 128},     '{3, 250, 7, 128});
`ifdef COFI_SHARPEN_CORING_EN
        seq4("core2",  15, 1'b0, 1'b1, '{100, 102, 102, 102}, '{100, 102, 102, 102});
        seq4("core4",  15, 1'b0, 1'b1, '{100, 104, 104, 104}, '{100, 107, 104, 104});
`else
        seq4("nocore2", 15, 1'b0, 1'b1, '{100, 102, 102, 102}, '{100, 103, 102, 102});
        seq4("nocore4", 15, 1'b0, 1'b1, '{100, 104, 104, 104}, '{100, 107, 104, 104});
`endif

        // Reset in the middle of a line.
        coefficient = 4'd8;
        scandoubler_disable = 1'b0;
        enable = 1'b1;
        hs = 1'b1;
        px(120, 120, 120, 1'b0);
        px(120, 120, 120, 1'b0);
        px(120, 120, 120, 1'b0);
        chk("pre-reset hs_out", int'(hs_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("midline reset red_out", int'(red_out), 0);
        chk("midline reset hblank_out", int'(hblank_out), 1);
        chk("midline reset hs_out", int'(hs_out), 0);
        hs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        px(200, 200, 200, 1'b0);
        px(60, 60, 60, 1'b0);
        chk("after reset first px", int'(red_out), 200);
        px(60, 60, 60, 1'b0);
        chk("after reset second px", int'(red_out), 0);

        // Randomized lines; the compare process checks every clock.
        for (int line = 0; line < 40; line++) begin
            coefficient = 4'($urandom_range(0, 15));
            scandoubler_disable = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 9) != 0);
            vs = (line % 10 == 0);
            vblank = (line % 10 < 2);
            blank_len = $urandom_range(6, 12);
            for (int i = 0; i < blank_len; i++) begin
                hs = (i >= 2 && i < 4);
                px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
            end
            hs = 1'b0;
            line_len = $urandom_range(20, 60);
            pv = $urandom_range(0, 255);
            for (int i = 0; i < line_len; i++) begin
                if ($urandom_range(0, 15) == 0) coefficient = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 31) == 0) enable = !enable;
                if ($urandom_range(0, 3) == 0) pv = $urandom_range(0, 255);
                else pv = clamp8(pv + $urandom_range(0, 6) - 3);
                px(pv, 255 - pv, $urandom_range(0, 255), 1'b0);
            end
        end
        enable = 1'b1;
        px(0, 0, 0, 1'b1);
        px(0, 0, 0, 1'b1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cofi_sharpen.md
Name: cofi_sharpen

Overview:
- Horizontal edge-enhancement (un-smear) filter for the RGB video chain; the complementary, high-pass direction of the composite-blend low-pass stage.
- Per channel it computes out = d + coeff*(d - prev)/16, saturated. It boosts the transitions a blur stage or analogue path softened.
- Sits in the same video-chain position as the blend filter, on the video-chain clock. Sync and blank signals are delayed to match its pipeline.

Parameters:
- VIDEO_DEPTH, 8, bits per colour channel.

Ports:
- clk  in  1  video-chain clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = sharpen; 0 = bypass with identical latency.
- coefficient  in  4  boost strength 0..15, in sixteenths.
- scandoubler_disable  in  1  1 = each pixel is held for 2 clocks; filter steps on alternate clocks.
- hblank  in  1  horizontal blank.
- vblank  in  1  vertical blank.
- hs  in  1  horizontal sync.
- vs  in  1  vertical sync.
- red  in  VIDEO_DEPTH  red channel.
- green  in  VIDEO_DEPTH  green channel.
- blue  in  VIDEO_DEPTH  blue channel.
- hblank_out  out  1  hblank delayed 2 clocks.
- vblank_out  out  1  vblank delayed 2 clocks.
- hs_out  out  1  hs delayed 2 clocks.
- vs_out  out  1  vs delayed 2 clocks.
- red_out  out  VIDEO_DEPTH  filtered red.
- green_out  out  VIDEO_DEPTH  filtered green.
- blue_out  out  VIDEO_DEPTH  filtered blue.

Behaviour:
- Reset (async, active-high):
  - All pipeline registers clear; colour outputs = 0.
  - hblank_out = vblank_out = 1; hs_out = vs_out = 0.
  - trigger = 1; line state = BLANK.
- Step enable:
  - trigger <= !trigger | hblank | !scandoubler_disable.
  - Result: every clock when scandoubler_disable=0; alternate clocks aligned to the first active clock after hblank otherwise.
- Line state machine (shared by all channels):
  - BLANK: entered while hblank=1, or while enable=0.
  - BLANK -> FIRST on the first trigger clock with hblank=0 and enable=1.
  - FIRST -> RUN after one step.
  - RUN -> BLANK when hblank=1 or enable=0, effective on that clock.
- Stage 1 (registered only when trigger=1), per channel:
  - delta = d - prev, signed VIDEO_DEPTH+1 bits.
  - delta is forced to 0 in BLANK and FIRST, so no bleed across lines.
  - prod = coefficient * delta, signed VIDEO_DEPTH+5 bits.
  - prev <= d; d is also registered.
  - When trigger=0, stage 1 holds, so a doubled pixel yields the same result on both clocks.
- Stage 2 (every clock):
  - sum = d_reg + (prod >>> 4), arithmetic shift, floor.
  - Saturate to 0..2^VIDEO_DEPTH-1; register to *_out.
- Latency: colour output is 2 clocks after the stage-1 sampling clock. Sync outputs pass through a 2-deep shift register so they stay aligned.
- enable=0: prod forced to 0, so out = d with the same 2-clock latency.
- coefficient changes take effect at the next stage-1 step; there is no glitch beyond that sample.
- coefficient=0: exact passthrough.
- Reset mid-line: outputs return to reset values at once. The first active pixel after release is treated as FIRST.

Optional Feature:
- Macro: COFI_SHARPEN_CORING_EN.
- Defined: noise coring. Any |delta| <= 2 is treated as 0 before the multiply, so flat noisy areas are not amplified.
- Undefined: no coring; every nonzero delta is boosted. Latency and ports are identical in both builds.

Test Plan:
- Flat line (VIDEO_DEPTH=8, coeff=8, scandoubler_disable=0): red=50 for every pixel -> red_out=50 every active clock, 2 clocks after input.
- Rising step (coeff=4): 100,100,132,132 -> 100,100,140,132. Saturation (coeff=8): 64 then 192 -> 192+64=256 -> red_out=255.
- Falling step (coeff=8): 192 then 64 -> delta=-128, prod>>>4=-64, out=0. With coeff=15, 200 then 0 -> clamped to 0.
- Line boundary: previous line ends at 10; first pixel after hblank is 200 -> out=200 (delta forced 0). hblank_out/hs_out edges lag inputs by exactly 2 clocks.
- Scandoubler_disable=1, coeff=4: pixels 100,132 each held 2 clocks -> outputs 100,100,140,140. enable=0 with the same stimulus -> 100,100,132,132.
- Assert reset mid-line -> outputs 0, hblank_out=1 immediately. Coring build, coeff=15: 100 then 102 -> out 102; 100 then 104 -> out 107.
